// File: rtl/forward_hazard_unit.sv
// Forwarding and load-use hazard unit for a classic five-stage pipeline.
// Keeps its own shadow copy of the ID/EX, EX/MEM and MEM/WB control fields.
//
// Ports:
//   inClk, inRstN       clock, asynchronous active-low reset
//   inId*               fields of the instruction currently in ID
//   inFlush             taken branch/jump in EX squashes the ID instruction
//   outForwardA/B       EX operand selects (00 regfile, 10 EX/MEM, 01 WB)
//   outStall            load-use stall this cycle
//   outPcWrite          PC update enable
//   outIfIdWrite        IF/ID register write enable
//   outIdExBubble       zero the control fields of the datapath ID/EX register
//   outStallCount       saturating count of stall cycles
module forward_hazard_unit (
    input  logic        inClk,
    input  logic        inRstN,
    input  logic [4:0]  inIdRs,
    input  logic [4:0]  inIdRt,
    input  logic [4:0]  inIdDest,
    input  logic        inIdRegWrite,
    input  logic        inIdMemRead,
    input  logic        inIdUsesRt,
    input  logic        inIdValid,
    input  logic        inFlush,
    output logic [1:0]  outForwardA,
    output logic [1:0]  outForwardB,
    output logic        outStall,
    output logic        outPcWrite,
    output logic        outIfIdWrite,
    output logic        outIdExBubble,
    output logic [15:0] outStallCount
);

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dest;
        logic       regWrite;
        logic       memRead;
    } idex_t;

    typedef struct packed {
        logic [4:0] dest;
        logic       regWrite;
        logic       memRead;
    } exmem_t;

    typedef struct packed {
        logic [4:0] dest;
        logic       regWrite;
    } memwb_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    idex_t       r_idex;
    exmem_t      r_exmem;
    memwb_t      r_memwb;
    logic [15:0] r_stall_cnt;

    idex_t       w_idex_next;
    logic        w_load_in_ex;
    logic        w_rs_hit;
    logic        w_rt_hit;
    logic        w_stall;
    logic        w_issue;

    // A load result is not available in EX/MEM, so only ALU results
    // are taken from there; the WB mux covers both ALU and load data.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input exmem_t     em,
        input memwb_t     mw
    );
        logic w_mem_hit;
        logic w_wb_hit;
        w_mem_hit = em.regWrite && !em.memRead &&
                    (em.dest != 5'd0) && (em.dest == src);
        w_wb_hit  = mw.regWrite && (mw.dest != 5'd0) &&
                    (mw.dest == src);
        if (w_mem_hit)
            fwd_sel = FWD_MEM;
        else if (w_wb_hit)
            fwd_sel = FWD_WB;
        else
            fwd_sel = FWD_RF;
    endfunction

    // Selects come only from the shadow stages.
    assign outForwardA = fwd_sel(r_idex.rs, r_exmem, r_memwb);
    assign outForwardB = fwd_sel(r_idex.rt, r_exmem, r_memwb);

    assign w_load_in_ex = r_idex.memRead && (r_idex.dest != 5'd0);
    assign w_rs_hit     = (r_idex.dest == inIdRs);
    assign w_rt_hit     = inIdUsesRt && (r_idex.dest == inIdRt);

    // A flush kills the ID instruction, so it can never cause a stall.
    assign w_stall = inIdValid && !inFlush && w_load_in_ex &&
                     (w_rs_hit || w_rt_hit);

    assign w_issue = inIdValid && !w_stall && !inFlush;

    always_comb begin
        w_idex_next = '0;
        if (w_issue) begin
            w_idex_next.rs       = inIdRs;
            w_idex_next.rt       = inIdRt;
            w_idex_next.dest     = inIdDest;
            w_idex_next.regWrite = inIdRegWrite;
            w_idex_next.memRead  = inIdMemRead;
        end
    end

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            r_idex  <= '0;
            r_exmem <= '0;
            r_memwb <= '0;
        end else begin
            r_idex           <= w_idex_next;
            r_exmem.dest     <= r_idex.dest;
            r_exmem.regWrite <= r_idex.regWrite;
            r_exmem.memRead  <= r_idex.memRead;
            r_memwb.dest     <= r_exmem.dest;
            r_memwb.regWrite <= r_exmem.regWrite;
        end
    end

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN)
            r_stall_cnt <= 16'd0;
        else if (w_stall && (r_stall_cnt != CNT_MAX))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign outStall      = w_stall;
    assign outPcWrite    = !w_stall;
    assign outIfIdWrite  = !w_stall;
    assign outIdExBubble = w_stall || inFlush;
    assign outStallCount = r_stall_cnt;

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 SHALL have port inClk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port inRstN, input, 1; asynchronous reset, active-low.
REQ-003 SHALL have port inIdRs, input, 5, rs field of the instruction in ID.
REQ-004 SHALL have port inIdRt, input, 5, rt field of the instruction in ID.
REQ-005 SHALL have port inIdDest, input, 5, resolved destination register of the ID instruction.
REQ-006 SHALL have port inIdRegWrite, input, 1, ID instruction writes the register file.
REQ-007 SHALL have port inIdMemRead, input, 1, ID instruction is a load.
REQ-008 SHALL have port inIdUsesRt, input, 1, ID instruction reads rt as a source.
REQ-009 SHALL have port inIdValid, input, 1, ID slot holds a real instruction.
REQ-010 SHALL have port inFlush, input, 1, branch/jump taken in EX; squash the ID instruction.
REQ-011 SHALL have port outForwardA, output, 2, EX operand-A select: 00 register file, 10 EX/MEM ALU result, 01 WB mux.
REQ-012 SHALL have port outForwardB, output, 2, EX operand-B select, same encoding.
REQ-013 SHALL have port outStall, output, 1, load-use stall active this cycle.
REQ-014 SHALL have port outPcWrite, output, 1, PC update enable.
REQ-015 SHALL have port outIfIdWrite, output, 1, IF/ID register write enable.
REQ-016 SHALL have port outIdExBubble, output, 1, zero the control fields of the datapath ID/EX register.
REQ-017 SHALL have port outStallCount, output, 16, saturating count of stall cycles.

Function
REQ-018 SHALL hold three shadow stages clocked on inClk: IDEX {rs, rt, dest, regWrite, memRead}, EXMEM {dest, regWrite, memRead}, MEMWB {dest, regWrite}.
REQ-019 SHALL advance EXMEM<=IDEX and MEMWB<=EXMEM on every clock, stall or not.
REQ-020 SHALL load IDEX from the inId* inputs when inIdValid=1, outStall=0 and inFlush=0; otherwise SHALL load IDEX with a bubble (all fields zero).
REQ-021 SHALL drive outForwardA=10 when EXMEM.regWrite=1, EXMEM.memRead=0, EXMEM.dest!=0 and EXMEM.dest==IDEX.rs.
REQ-022 SHALL otherwise drive outForwardA=01 when MEMWB.regWrite=1, MEMWB.dest!=0 and MEMWB.dest==IDEX.rs; else 00.
REQ-023 SHALL compute outForwardB identically against IDEX.rt; EX/MEM match has priority over MEM/WB.
REQ-024 SHALL never output 11 on either forward select; register 0 SHALL never forward.
REQ-025 SHALL assert outStall combinationally when inIdValid=1, inFlush=0, IDEX.memRead=1, IDEX.dest!=0, and (IDEX.dest==inIdRs or (inIdUsesRt=1 and IDEX.dest==inIdRt)).
REQ-026 SHALL drive outPcWrite=outIfIdWrite=NOT outStall, and outIdExBubble=outStall OR inFlush.
REQ-027 SHALL produce exactly one stall cycle per load-use hazard (the inserted bubble clears IDEX.memRead).
REQ-028 SHALL give inFlush priority over stall: with both conditions present, outStall=0, PC/IF-ID writes enabled, IDEX bubbled.
REQ-029 SHALL increment outStallCount on each clock with outStall=1, saturating at 16'hFFFF without wrap.
REQ-030 SHALL produce no combinational path from inId* to outForwardA/B (selects depend on shadow stages only).

Reset
REQ-031 SHALL, on inRstN=0 (asynchronous), clear all shadow stages and outStallCount to 0, giving outForwardA=outForwardB=00, outStall=0, outPcWrite=1, outIfIdWrite=1, outIdExBubble=0 (inFlush=0).
REQ-032 SHALL restart from the cleared state when reset is applied mid-stall, with no residual stall after release.

Verification
REQ-033 SHALL pass: add r3 issued, next add reads rs=r3 -> next cycle outForwardA=10; one cycle later with unrelated instruction between -> 01.
REQ-034 SHALL pass: lw r5 followed by add rt=r5, inIdUsesRt=1 -> outStall=1 for exactly one cycle, outPcWrite=0, outStallCount 0->1, then outForwardB=01.
REQ-035 SHALL pass: lw r5 followed by add using r5 with inFlush=1 same cycle -> outStall=0, outIdExBubble=1, no forwarding afterwards.
REQ-036 SHALL pass: instruction writing r0 followed by reader of r0 -> forwards stay 00.
REQ-037 SHALL pass: EX/MEM and MEM/WB both target r7, EX reads r7 on A and B -> both selects 10.
REQ-038 SHALL pass: force 65536 stall cycles -> outStallCount holds 16'hFFFF; assert inRstN=0 asynchronously -> all outputs at REQ-031 values before next edge.
